pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock, sole clock domain.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 id_valid  input  1  IF/ID register holds a live instruction.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the ID instruction.
REQ-005 id_read_rs, id_read_rt  input  1 each  decoder readRs/readRt qualifiers.
REQ-006 id_reg_wr  input  1  decoder RegWr.
REQ-007 id_wr_reg  input  5  destination after RegDst mux.
REQ-008 id_mem_to_reg  input  1  decoder MemToReg; 1 marks a load.
REQ-009 id_jump, id_jump_r  input  1 each  decoder Jump/JumpR.
REQ-010 ex_branch_taken  input  1  bltz resolved taken in EX this cycle.
REQ-011 stall_if_id  output  1  hold PC and IF/ID.
REQ-012 bubble_ex  output  1  load NOP into ID/EX instead of the ID instruction.
REQ-013 flush_if_id  output  1  replace IF/ID contents with NOP at next edge.
REQ-014 fwd_a_sel, fwd_b_sel  output  2 each  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB; 11 unused.
REQ-015 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-016 Block SHALL keep a two-entry shadow pipeline (EX, MEM), each entry {valid, reg_wr, load, wr_reg}.
REQ-017 Every cycle MEM SHALL take EX; EX SHALL take ID info if id_valid and not bubble_ex, else an invalid entry.
REQ-018 Register 0 SHALL never match any hazard or forwarding comparison.
REQ-019 Load-use hazard: EX entry valid load, wr_reg equals an ID source with its read qualifier set -> stall_if_id=1, bubble_ex=1 for exactly 1 cycle.
REQ-020 JR hazard: id_jump_r with id_rs matching a valid reg_wr EX entry, or a valid load MEM entry -> stall_if_id=1, bubble_ex=1 until cleared (max 2 cycles).
REQ-021 FSM states RUN, LU_STALL, JR_STALL: RUN->LU_STALL on REQ-019, RUN->JR_STALL on REQ-020, either stall state->RUN when its hazard evaluates false; LU_STALL SHALL last 1 cycle.
REQ-022 Accepted jump (id_jump or id_jump_r, id_valid, no stall) SHALL assert flush_if_id that cycle.
REQ-023 ex_branch_taken SHALL assert flush_if_id=1 and bubble_ex=1, stall_if_id=0, and force FSM to RUN; it overrides every stall and jump.
REQ-024 Forward select for rs (rt alike): read qualifier set and EX entry matches -> 01; else MEM entry matches -> 10; else 00; EX priority over MEM.
REQ-025 fwd_*_sel SHALL be registered at the edge the ID instruction enters EX; a bubble SHALL register 00.
REQ-026 stall_if_id, bubble_ex, flush_if_id SHALL be combinational from state, shadow entries and inputs; zero-cycle decision latency.
REQ-027 stall_cnt SHALL increment each cycle stall_if_id=1 and hold at 16'hFFFF.
REQ-028 id_valid=0 SHALL raise no hazard and no jump flush.

Reset
REQ-029 On reset: FSM RUN, shadow entries invalid, fwd_*_sel 00, stall_cnt 0; stall_if_id, bubble_ex, flush_if_id 0 in the first post-reset cycle.
REQ-030 Reset mid-stall SHALL abandon the stall; no stall counted in the reset cycle.

Structure
REQ-031 Shared package SHALL hold fwd-select encoding constants, FSM state enum, shadow-entry struct.
REQ-032 One sub-module pipe_fwd_sel (combinational per-operand select) SHALL be instantiated twice.

Verification
REQ-033 lw $8 then subu $9,$8,$10 -> 1 cycle stall_if_id=1, bubble_ex=1; then fwd_a_sel=10; stall_cnt=1.
REQ-034 addi $8 then subu $9,$8,$8 back-to-back -> no stall, fwd_a_sel=01, fwd_b_sel=01.
REQ-035 addi $31 then jr $31 -> 1 stall cycle, then flush_if_id=1 on jr accept.
REQ-036 ex_branch_taken=1 coincident with load-use hazard -> flush_if_id=1, bubble_ex=1, stall_if_id=0, stall_cnt unchanged.
REQ-037 Writer to $0 followed by reader of $0 -> no stall, selects 00.
REQ-038 Force 70000 consecutive stalls -> stall_cnt holds 16'hFFFF; reset -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    // EX operand source encodings
    localparam logic [1:0] fwd_rf    = 2'b00;
    localparam logic [1:0] fwd_exmem = 2'b01;
    localparam logic [1:0] fwd_memwb = 2'b10;

    typedef enum logic [1:0] {
        st_run      = 2'b00,
        st_lu_stall = 2'b01,
        st_jr_stall = 2'b10
    } hz_state_t;

    // One stage of the shadow pipeline tracking what is in flight ahead of ID
    typedef struct packed {
        logic       valid;
        logic       reg_wr;
        logic       load;
        logic [4:0] wr_reg;
    } shadow_t;

    // True when a valid writer in this stage produces register r ($0 never matches)
    function automatic logic fwd_hit(input shadow_t e, input logic [4:0] r);
        return e.valid && e.reg_wr && (e.wr_reg != 5'd0) && (e.wr_reg == r);
    endfunction

    // True when a valid load in this stage produces register r ($0 never matches)
    function automatic logic load_hit(input shadow_t e, input logic [4:0] r);
        return e.valid && e.load && (e.wr_reg != 5'd0) && (e.wr_reg == r);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// rtl/pipe_fwd_sel.sv - per-operand forwarding source select
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       rd_en,
    input  logic [4:0] src,
    input  shadow_t    ex_e,
    input  shadow_t    mem_e,
    output logic [1:0] sel
);

    // Youngest producer wins: the EX entry shadows an older MEM write of the same register
    always_comb begin
        sel = fwd_rf;
        if (rd_en && fwd_hit(ex_e, src)) begin
            sel = fwd_exmem;
        end else if (rd_en && fwd_hit(mem_e, src)) begin
            sel = fwd_memwb;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / jr stall, jump/branch flush and forwarding control
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_read_rs,
    input  logic        id_read_rt,
    input  logic        id_reg_wr,
    input  logic [4:0]  id_wr_reg,
    input  logic        id_mem_to_reg,
    input  logic        id_jump,
    input  logic        id_jump_r,
    input  logic        ex_branch_taken,
    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic        flush_if_id,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [15:0] stall_cnt
);

    hz_state_t  state;
    shadow_t    ex_e;
    shadow_t    mem_e;
    shadow_t    id_e;
    logic       lu_hit;
    logic       lu_hazard;
    logic       jr_hazard;
    logic       stall_req;
    logic       enter_ex;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign id_e = '{valid: 1'b1, reg_wr: id_reg_wr, load: id_mem_to_reg, wr_reg: id_wr_reg};

    // A load in EX feeding either live source of the ID instruction
    assign lu_hit = (id_read_rs && load_hit(ex_e, id_rs)) ||
                    (id_read_rt && load_hit(ex_e, id_rt));

    // The bubble inserted by a load-use stall always clears it, so it is masked after one cycle
    assign lu_hazard = id_valid && (state != st_lu_stall) && lu_hit;

    // jr resolves its target in ID, so it waits for any EX producer or a load still in MEM
    assign jr_hazard = id_valid && id_jump_r &&
                       (fwd_hit(ex_e, id_rs) || load_hit(mem_e, id_rs));

    // A taken branch squashes the ID instruction, so no stall is needed for it
    assign stall_req   = (lu_hazard || jr_hazard) && !ex_branch_taken;
    assign stall_if_id = stall_req;
    assign bubble_ex   = stall_req || ex_branch_taken;
    assign flush_if_id = ex_branch_taken ||
                         (id_valid && (id_jump || id_jump_r) && !stall_req);

    assign enter_ex = id_valid && !bubble_ex;

    pipe_fwd_sel u_fwd_a (
        .rd_en (id_read_rs),
        .src   (id_rs),
        .ex_e  (ex_e),
        .mem_e (mem_e),
        .sel   (sel_a)
    );

    pipe_fwd_sel u_fwd_b (
        .rd_en (id_read_rt),
        .src   (id_rt),
        .ex_e  (ex_e),
        .mem_e (mem_e),
        .sel   (sel_b)
    );

    // Stall-tracking FSM; a taken branch always returns it to RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= st_run;
        end else if (ex_branch_taken) begin
            state <= st_run;
        end else begin
            case (state)
                st_run: begin
                    if (jr_hazard) begin
                        state <= st_jr_stall;
                    end else if (lu_hazard) begin
                        state <= st_lu_stall;
                    end
                end
                st_lu_stall: begin
                    state <= jr_hazard ? st_jr_stall : st_run;
                end
                st_jr_stall: begin
                    state <= jr_hazard ? st_jr_stall : st_run;
                end
                default: begin
                    state <= st_run;
                end
            endcase
        end
    end

    // Shadow pipeline advances every cycle; bubbles enter EX as invalid entries
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_e  <= '0;
            mem_e <= '0;
        end else begin
            mem_e <= ex_e;
            ex_e  <= enter_ex ? id_e : '0;
        end
    end

    // Forward selects travel with the instruction into EX; a bubble carries regfile select
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_sel <= fwd_rf;
            fwd_b_sel <= fwd_rf;
        end else if (enter_ex) begin
            fwd_a_sel <= sel_a;
            fwd_b_sel <= sel_b;
        end else begin
            fwd_a_sel <= fwd_rf;
            fwd_b_sel <= fwd_rf;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (stall_req && (stall_cnt != 16'hffff)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_read_rs;
    logic        id_read_rt;
    logic        id_reg_wr;
    logic [4:0]  id_wr_reg;
    logic        id_mem_to_reg;
    logic        id_jump;
    logic        id_jump_r;
    logic        ex_branch_taken;
    logic        stall_if_id;
    logic        bubble_ex;
    logic        flush_if_id;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_read_rs      (id_read_rs),
        .id_read_rt      (id_read_rt),
        .id_reg_wr       (id_reg_wr),
        .id_wr_reg       (id_wr_reg),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_jump         (id_jump),
        .id_jump_r       (id_jump_r),
        .ex_branch_taken (ex_branch_taken),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_cnt       (stall_cnt)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rd_rs;
        logic       rd_rt;
        logic       reg_wr;
        logic [4:0] wr;
        logic       m2r;
        logic       j;
        logic       jr;
        logic       br;
    } in_t;

    typedef struct {
        string       name;
        bit          c_ctl;
        logic        s;
        logic        b;
        logic        f;
        bit          c_fwd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        bit          c_cnt;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic in_t nop();
        in_t v;
        v = '{valid: 1'b0, rs: 5'd0, rt: 5'd0, rd_rs: 1'b0, rd_rt: 1'b0, reg_wr: 1'b0,
              wr: 5'd0, m2r: 1'b0, j: 1'b0, jr: 1'b0, br: 1'b0};
        return v;
    endfunction

    function automatic in_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                                input logic rrs, input logic rrt);
        in_t v;
        v = nop();
        v.valid = 1'b1; v.rs = rs; v.rt = rt; v.rd_rs = rrs; v.rd_rt = rrt;
        v.reg_wr = 1'b1; v.wr = wr;
        return v;
    endfunction

    function automatic in_t lw(input logic [4:0] base, input logic [4:0] wr);
        in_t v;
        v = alu(base, wr, wr, 1'b1, 1'b0);
        v.m2r = 1'b1;
        return v;
    endfunction

    function automatic in_t jr(input logic [4:0] rs);
        in_t v;
        v = nop();
        v.valid = 1'b1; v.rs = rs; v.rd_rs = 1'b1; v.jr = 1'b1;
        return v;
    endfunction

    function automatic in_t jmp();
        in_t v;
        v = nop();
        v.valid = 1'b1; v.j = 1'b1;
        return v;
    endfunction

    function automatic exp_t full(input string n, input logic s, input logic b, input logic f,
                                  input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
        exp_t e;
        e = '{name: n, c_ctl: 1'b1, s: s, b: b, f: f, c_fwd: 1'b1, fa: fa, fb: fb,
              c_cnt: 1'b1, cnt: cnt};
        return e;
    endfunction

    function automatic exp_t cnt_only(input string n, input logic [15:0] cnt);
        exp_t e;
        e = full(n, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, cnt);
        e.c_ctl = 1'b0;
        e.c_fwd = 1'b0;
        return e;
    endfunction

    task automatic apply(input in_t v);
        id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
        id_read_rs = v.rd_rs; id_read_rt = v.rd_rt;
        id_reg_wr = v.reg_wr; id_wr_reg = v.wr; id_mem_to_reg = v.m2r;
        id_jump = v.j; id_jump_r = v.jr; ex_branch_taken = v.br;
    endtask

    task automatic cyc(input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, got, want);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare what the DUT presents
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            if (m_e.c_ctl) begin
                chk({m_e.name, ".stall_if_id"}, {15'd0, stall_if_id}, {15'd0, m_e.s});
                chk({m_e.name, ".bubble_ex"},   {15'd0, bubble_ex},   {15'd0, m_e.b});
                chk({m_e.name, ".flush_if_id"}, {15'd0, flush_if_id}, {15'd0, m_e.f});
            end
            if (m_e.c_fwd) begin
                chk({m_e.name, ".fwd_a_sel"}, {14'd0, fwd_a_sel}, {14'd0, m_e.fa});
                chk({m_e.name, ".fwd_b_sel"}, {14'd0, fwd_b_sel}, {14'd0, m_e.fb});
            end
            if (m_e.c_cnt) begin
                chk({m_e.name, ".stall_cnt"}, stall_cnt, m_e.cnt);
            end
        end
    end

    initial begin
        in_t v;
        reset = 1'b1;
        apply(nop());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(full("post_reset", 0, 0, 0, 2'b00, 2'b00, 16'd0));

        // lw $8 ; subu $9,$8,$10
        cyc(lw(9, 8),              full("lw_issue",    0, 0, 0, 2'b00, 2'b00, 16'd0));
        cyc(alu(8, 10, 9, 1, 1),   full("lu_stall",    1, 1, 0, 2'b00, 2'b00, 16'd0));
        cyc(alu(8, 10, 9, 1, 1),   full("lu_release",  0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(nop(),                 full("lu_fwd",      0, 0, 0, 2'b10, 2'b00, 16'd1));
        // addi $8 ; subu $9,$8,$8
        cyc(alu(0, 0, 8, 1, 0),    full("addi8",       0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(alu(8, 8, 9, 1, 1),    full("b2b_nostall", 0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(nop(),                 full("b2b_fwd",     0, 0, 0, 2'b01, 2'b01, 16'd1));
        // two writers of $8: the younger one must win
        cyc(alu(0, 0, 8, 1, 0),    full("addi8_b",     0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(alu(8, 0, 8, 1, 0),    full("ori8",        0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(alu(8, 9, 10, 1, 1),   full("two_writers", 0, 0, 0, 2'b01, 2'b00, 16'd1));
        cyc(nop(),                 full("ex_priority", 0, 0, 0, 2'b01, 2'b00, 16'd1));
        // load to $0 then readers of $0
        cyc(lw(5, 0),              full("lw_r0",       0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(alu(0, 0, 9, 1, 1),    full("r0_nostall",  0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(alu(0, 0, 11, 1, 1),   full("r0_ex",       0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(nop(),                 full("r0_mem",      0, 0, 0, 2'b00, 2'b00, 16'd1));
        // addi $31 ; jr $31
        cyc(alu(0, 0, 31, 1, 0),   full("addi31",      0, 0, 0, 2'b00, 2'b00, 16'd1));
        cyc(jr(31),                full("jr_stall",    1, 1, 0, 2'b00, 2'b00, 16'd1));
        cyc(jr(31),                full("jr_accept",   0, 0, 1, 2'b00, 2'b00, 16'd2));
        cyc(nop(),                 full("jr_fwd",      0, 0, 0, 2'b10, 2'b00, 16'd2));
        // lw $31 ; jr $31 stalls two cycles
        cyc(lw(29, 31),            full("lw31",        0, 0, 0, 2'b00, 2'b00, 16'd2));
        cyc(jr(31),                full("jr_lw_1",     1, 1, 0, 2'b00, 2'b00, 16'd2));
        cyc(jr(31),                full("jr_lw_2",     1, 1, 0, 2'b00, 2'b00, 16'd3));
        cyc(jr(31),                full("jr_lw_accept",0, 0, 1, 2'b00, 2'b00, 16'd4));
        cyc(nop(),                 full("jr_lw_fwd",   0, 0, 0, 2'b00, 2'b00, 16'd4));
        cyc(jmp(),                 full("j_flush",     0, 0, 1, 2'b00, 2'b00, 16'd4));
        // invalid ID raises nothing even with hazard-shaped fields
        cyc(lw(0, 12),             full("lw12",        0, 0, 0, 2'b00, 2'b00, 16'd4));
        v = jr(12); v.valid = 1'b0; v.j = 1'b1; v.rt = 5'd12; v.rd_rt = 1'b1;
        cyc(v,                     full("invalid_id",  0, 0, 0, 2'b00, 2'b00, 16'd4));
        cyc(nop(),                 full("invalid_fwd", 0, 0, 0, 2'b00, 2'b00, 16'd4));
        // taken branch overrides load-use stall and jump
        cyc(lw(0, 8),              full("lw8_b",       0, 0, 0, 2'b00, 2'b00, 16'd4));
        v = alu(8, 10, 9, 1, 1); v.br = 1'b1;
        cyc(v,                     full("br_over_lu",  0, 1, 1, 2'b00, 2'b00, 16'd4));
        cyc(nop(),                 full("br_cnt",      0, 0, 0, 2'b00, 2'b00, 16'd4));
        v = jmp(); v.br = 1'b1;
        cyc(v,                     full("br_over_j",   0, 1, 1, 2'b00, 2'b00, 16'd4));
        cyc(nop(),                 full("br_j_after",  0, 0, 0, 2'b00, 2'b00, 16'd4));
        // reset during a load-use stall
        cyc(lw(0, 8),              full("lw8_c",       0, 0, 0, 2'b00, 2'b00, 16'd4));
        @(posedge clk);
        #1;
        apply(alu(8, 10, 9, 1, 1));
        reset = 1'b1;
        exp_q.push_back(cnt_only("rst_mid_cnt", 16'd4));
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(alu(8, 10, 9, 1, 1));
        exp_q.push_back(full("after_mid_reset", 0, 0, 0, 2'b00, 2'b00, 16'd0));
        cyc(nop(),                 full("after_mid_fwd", 0, 0, 0, 2'b00, 2'b00, 16'd0));
        // saturation: hold the stall request for 70000 cycles
        @(posedge clk);
        #1;
        apply(nop());
        force dut.stall_req = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        release dut.stall_req;
        exp_q.push_back(cnt_only("saturate", 16'hffff));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(full("sat_reset", 0, 0, 0, 2'b00, 2'b00, 16'd0));

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL watchdog got timeout want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
